// File: rtl/dtlb_req_buffer_pkg.sv
// Shared types and sizing constants for the DTLB request front-end.
// tlb_req_t is the hart-wide request record; the buffer stores it unchanged.
package dtlb_req_buffer_pkg;

    localparam int NUM_OF_REQ_TO_DTLB = 2;
    localparam int NUM_OF_DTLB_LOOKUP = 2;
    localparam int DTLB_REQ_BUF_DEPTH = 8;
    localparam int VADDR_W            = 32;

    typedef struct packed {
        logic               valid;
        logic [VADDR_W-1:0] vaddr;
        logic               is_store;
        logic [3:0]         lsu_tag;
    } tlb_req_t;

endpackage

// File: rtl/dtlb_req_compactor.sv
// Prefix-count of a lane valid vector: each lane gets the number of valid lanes
// below it (its slot offset), plus the total count. Purely combinational.
module dtlb_req_compactor #(
    parameter int NUM_OF_REQ = 2,
    parameter int OFF_W      = $clog2(NUM_OF_REQ + 1)
) (
    input  logic [NUM_OF_REQ-1:0]            i_valid_vec,
    output logic [NUM_OF_REQ-1:0][OFF_W-1:0] o_lane_offset,
    output logic [OFF_W-1:0]                 o_n_enq
);

    logic [OFF_W-1:0] w_cnt;

    always_comb begin
        w_cnt         = '0;
        o_lane_offset = '0;
        for (int i = 0; i < NUM_OF_REQ; i++) begin
            o_lane_offset[i] = w_cnt;
            w_cnt            = w_cnt + OFF_W'(i_valid_vec[i]);
        end
        o_n_enq = w_cnt;
    end

endmodule

// File: rtl/dtlb_req_buffer.sv
// In-order circular buffer between the LSU request lanes and the DTLB lookup
// ports. Lookup outputs and stall depend on registered state only.
module dtlb_req_buffer
    import dtlb_req_buffer_pkg::*;
#(
    parameter int NUM_OF_REQ    = NUM_OF_REQ_TO_DTLB,
    parameter int NUM_OF_LOOKUP = NUM_OF_DTLB_LOOKUP,
    parameter int DEPTH         = DTLB_REQ_BUF_DEPTH,
    parameter int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  tlb_req_t [NUM_OF_REQ-1:0]     req,
    output logic                          stall_req_to_dtlb,
    output tlb_req_t [NUM_OF_LOOKUP-1:0]  lookup_req,
    input  logic                          lookup_ready,
    output logic [CNT_W-1:0]              occupancy,
    output logic                          overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(NUM_OF_REQ + 1);

    tlb_req_t         r_entry [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_occ;
    logic             r_ovf;

    logic [NUM_OF_REQ-1:0]            w_valid_vec;
    logic [NUM_OF_REQ-1:0][OFF_W-1:0] w_lane_off;
    logic [OFF_W-1:0]                 w_n_enq;
    logic [NUM_OF_REQ-1:0]            w_accept;
    logic [CNT_W-1:0]                 w_free;
    logic [CNT_W-1:0]                 w_n_acc;
    logic [CNT_W-1:0]                 w_n_lk;
    logic [CNT_W-1:0]                 w_n_deq;

    always_comb begin
        w_valid_vec = '0;
        for (int i = 0; i < NUM_OF_REQ; i++) begin
            w_valid_vec[i] = req[i].valid;
        end
    end

    dtlb_req_compactor #(
        .NUM_OF_REQ (NUM_OF_REQ),
        .OFF_W      (OFF_W)
    ) u_compactor (
        .i_valid_vec   (w_valid_vec),
        .o_lane_offset (w_lane_off),
        .o_n_enq       (w_n_enq)
    );

    // Free space excludes slots dequeued this cycle; they become usable next cycle.
    always_comb begin
        w_free   = CNT_W'(DEPTH) - r_occ;
        w_n_acc  = (CNT_W'(w_n_enq) > w_free) ? w_free : CNT_W'(w_n_enq);
        w_accept = '0;
        for (int i = 0; i < NUM_OF_REQ; i++) begin
            w_accept[i] = req[i].valid && (CNT_W'(w_lane_off[i]) < w_free);
        end
        w_n_lk  = (r_occ > CNT_W'(NUM_OF_LOOKUP)) ? CNT_W'(NUM_OF_LOOKUP) : r_occ;
        w_n_deq = lookup_ready ? w_n_lk : '0;
    end

    always_comb begin
        lookup_req = '0;
        for (int i = 0; i < NUM_OF_LOOKUP; i++) begin
            lookup_req[i]       = r_entry[r_head + PTR_W'(i)];
            lookup_req[i].valid = CNT_W'(i) < r_occ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_ovf  <= 1'b0;
            for (int d = 0; d < DEPTH; d++) begin
                r_entry[d].valid <= 1'b0;
            end
        end else begin
            // Retired and newly written slots never coincide, so order is irrelevant.
            for (int k = 0; k < NUM_OF_LOOKUP; k++) begin
                if (CNT_W'(k) < w_n_deq) begin
                    r_entry[r_head + PTR_W'(k)].valid <= 1'b0;
                end
            end
            for (int i = 0; i < NUM_OF_REQ; i++) begin
                if (w_accept[i]) begin
                    r_entry[r_tail + PTR_W'(w_lane_off[i])] <= req[i];
                end
            end
            r_tail <= r_tail + PTR_W'(w_n_acc);
            r_head <= r_head + PTR_W'(w_n_deq);
            r_occ  <= r_occ + w_n_acc - w_n_deq;
            r_ovf  <= CNT_W'(w_n_enq) > w_free;
        end
    end

    assign stall_req_to_dtlb = w_free < CNT_W'(NUM_OF_REQ);
    assign occupancy         = r_occ;
    assign overflow_err      = r_ovf;

endmodule

// File: tb/tb_dtlb_req_buffer.sv
// Bench for dtlb_req_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dtlb_req_buffer;
    import dtlb_req_buffer_pkg::*;

    localparam int NR    = 2;
    localparam int NL    = 2;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 lookup_ready;
    tlb_req_t [NR-1:0]    req;
    tlb_req_t [NL-1:0]    lookup_req;
    logic                 stall;
    logic [CNT_W-1:0]     occupancy;
    logic                 overflow_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dtlb_req_buffer #(
        .NUM_OF_REQ    (NR),
        .NUM_OF_LOOKUP (NL),
        .DEPTH         (DEPTH),
        .CNT_W         (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .req               (req),
        .stall_req_to_dtlb (stall),
        .lookup_req        (lookup_req),
        .lookup_ready      (lookup_ready),
        .occupancy         (occupancy),
        .overflow_err      (overflow_err)
    );

    // Reference model: the buffer is just an ordered queue of accepted requests.
    tlb_req_t exp_q[$];
    bit       m_ovf  = 1'b0;
    bit       m_init = 1'b0;

    always @(posedge clk) begin : model
        int free;
        int nd;
        if (!rst_n) begin
            exp_q.delete();
            m_ovf  = 1'b0;
            m_init = 1'b1;
        end else if (flush) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            free  = DEPTH - exp_q.size();
            nd    = lookup_ready ? ((exp_q.size() < NL) ? exp_q.size() : NL) : 0;
            m_ovf = 1'b0;
            for (int i = 0; i < nd; i++) void'(exp_q.pop_front());
            for (int i = 0; i < NR; i++) begin
                if (req[i].valid) begin
                    if (free > 0) begin
                        exp_q.push_back(req[i]);
                        free--;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (m_ovf) $display("note: request overflow presented at %0t (protocol violation)", $time);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            check("occupancy", 64'(occupancy), 64'(exp_q.size()));
            check("stall", 64'(stall), 64'((DEPTH - exp_q.size()) < NR));
            check("overflow_err", 64'(overflow_err), 64'(m_ovf));
            for (int i = 0; i < NL; i++) begin
                if (i < exp_q.size())
                    check($sformatf("lookup_req[%0d]", i), 64'(lookup_req[i]), 64'(exp_q[i]));
                else
                    check($sformatf("lookup_valid[%0d]", i), 64'(lookup_req[i].valid), 64'(0));
            end
        end
    end

    task automatic drive(input logic [NR-1:0] v, input logic [31:0] base,
                         input bit rdy, input bit fl, input bit rst);
        for (int i = 0; i < NR; i++) begin
            req[i].valid    = v[i];
            req[i].vaddr    = base + 32'(i);
            req[i].is_store = 1'($urandom_range(0, 1));
            req[i].lsu_tag  = 4'(i);
        end
        lookup_ready = rdy;
        flush        = fl;
        rst_n        = !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_empty(input string tag);
        check({tag, "_occ"}, 64'(occupancy), 64'(0));
        check({tag, "_stall"}, 64'(stall), 64'(0));
        check({tag, "_lk0_valid"}, 64'(lookup_req[0].valid), 64'(0));
        check({tag, "_lk1_valid"}, 64'(lookup_req[1].valid), 64'(0));
    endtask

    initial begin
        logic [NR-1:0] v;
        rst_n        = 1'b0;
        flush        = 1'b0;
        lookup_ready = 1'b0;
        req          = '0;

        // Reset held while lanes are active: nothing may be enqueued.
        repeat (3) drive(2'b11, 32'h10, 1'b1, 1'b0, 1'b1);
        expect_empty("reset");
        check("reset_ovf", 64'(overflow_err), 64'(0));
        drive(2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

        // Fill with both lanes, no lookups: 2,4,6,8; stall only once free < 2.
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 32'h100 + 32'(2 * k), 1'b0, 1'b0, 1'b0);
            check("fill_occ", 64'(occupancy), 64'(2 * (k + 1)));
            check("fill_stall", 64'(stall), 64'(k == 3));
        end

        // Full plus lookup plus illegal pushes: 2 out, 0 in, overflow next cycle.
        drive(2'b11, 32'h1F0, 1'b1, 1'b0, 1'b0);
        check("full_occ", 64'(occupancy), 64'(6));
        check("full_ovf", 64'(overflow_err), 64'(1));
        check("full_head", 64'(lookup_req[0].vaddr), 64'(32'h102));
        drive(2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        check("ovf_pulse_end", 64'(overflow_err), 64'(0));

        // Reach occupancy 5, then flush with simultaneous req and ready.
        drive(2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(2'b01, 32'h300, 1'b0, 1'b0, 1'b0);
        check("pre_flush_occ", 64'(occupancy), 64'(5));
        drive(2'b11, 32'h400, 1'b1, 1'b1, 1'b0);
        expect_empty("flush");

        // Sparse lanes: lane1 first, then lane0, in order without gaps.
        drive(2'b10, 32'hA00, 1'b1, 1'b0, 1'b0);
        check("sparse_a_valid", 64'(lookup_req[0].valid), 64'(1));
        check("sparse_a_addr", 64'(lookup_req[0].vaddr), 64'(32'hA01));
        check("sparse_a_lk1", 64'(lookup_req[1].valid), 64'(0));
        drive(2'b01, 32'hB00, 1'b1, 1'b0, 1'b0);
        check("sparse_b_addr", 64'(lookup_req[0].vaddr), 64'(32'hB00));
        check("sparse_b_occ", 64'(occupancy), 64'(1));
        drive(2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        check("sparse_drain", 64'(occupancy), 64'(0));
        drive(2'b00, 32'h0, 1'b0, 1'b1, 1'b0);

        // Wrap: push 6, pop 6, push 4 so entries sit at indices 6,7,0,1.
        for (int k = 0; k < 3; k++) drive(2'b11, 32'h500 + 32'(2 * k), 1'b0, 1'b0, 1'b0);
        check("wrap_push_occ", 64'(occupancy), 64'(6));
        repeat (3) drive(2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        check("wrap_pop_occ", 64'(occupancy), 64'(0));
        for (int k = 0; k < 2; k++) drive(2'b11, 32'h600 + 32'(2 * k), 1'b0, 1'b0, 1'b0);
        check("wrap_occ", 64'(occupancy), 64'(4));
        check("wrap_lk0", 64'(lookup_req[0].vaddr), 64'(32'h600));
        check("wrap_lk1", 64'(lookup_req[1].vaddr), 64'(32'h601));
        drive(2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        check("wrap_lk0_b", 64'(lookup_req[0].vaddr), 64'(32'h602));
        check("wrap_lk1_b", 64'(lookup_req[1].vaddr), 64'(32'h603));
        drive(2'b00, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of traffic.
        drive(2'b11, 32'h700, 1'b0, 1'b0, 1'b0);
        drive(2'b11, 32'h702, 1'b0, 1'b0, 1'b0);
        check("mid_pre_occ", 64'(occupancy), 64'(4));
        drive(2'b11, 32'h800, 1'b1, 1'b0, 1'b1);
        expect_empty("mid_reset");

        // Randomized traffic; requesters mostly honour stall, with rare violations.
        for (int c = 0; c < 3000; c++) begin
            v = NR'($urandom);
            if ((DEPTH - exp_q.size()) < NR && $urandom_range(0, 99) >= 3) v = '0;
            drive(v, $urandom, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end
        drive(2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
